// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single pair-write port between
// requester A (ALU writeback) and requester B (load writeback).
// Each requester owns a 1-entry holding buffer (EMPTY/HELD) behind a
// valid/ready handshake. A round-robin grant picks one held entry per cycle,
// and the winner is loaded into registered outputs that drive the register file.
// A write to address 0 is accepted and granted, but it never raises rf_write_en.
// Optional feature macro: RF_BYPASS_EN adds combinational read forwarding
// from the pending register-file write to two read ports.
module rf_write_arbiter #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [D-1:0] a_waddr,
  input  logic [W-1:0] a_dataA,
  input  logic [W-1:0] a_dataB,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [D-1:0] b_waddr,
  input  logic [W-1:0] b_dataA,
  input  logic [W-1:0] b_dataB,
  output logic         rf_write_en,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_data_inA,
  output logic [W-1:0] rf_data_inB,
  output logic [7:0]   stall_cnt
`ifdef RF_BYPASS_EN
  ,
  input  logic [D-1:0] rd_addrA,
  input  logic [D-1:0] rd_addrB,
  input  logic [W-1:0] rf_doutA,
  input  logic [W-1:0] rf_doutB,
  output logic [W-1:0] byp_doutA,
  output logic [W-1:0] byp_doutB
`endif
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} buf_state_e;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;

  // Holding buffer state and contents
  buf_state_e   a_state_q, a_state_d;
  buf_state_e   b_state_q, b_state_d;
  logic [D-1:0] a_waddr_q, a_waddr_d;
  logic [W-1:0] a_dataA_q, a_dataA_d;
  logic [W-1:0] a_dataB_q, a_dataB_d;
  logic [D-1:0] b_waddr_q, b_waddr_d;
  logic [W-1:0] b_dataA_q, b_dataA_d;
  logic [W-1:0] b_dataB_q, b_dataB_d;

  // Arbitration history
  gnt_e         last_grant_q, last_grant_d;

  // Registered register-file drive and stall statistic
  logic         rf_write_en_q, rf_write_en_d;
  logic [D-1:0] rf_waddr_q, rf_waddr_d;
  logic [W-1:0] rf_data_inA_q, rf_data_inA_d;
  logic [W-1:0] rf_data_inB_q, rf_data_inB_d;
  logic [7:0]   stall_cnt_q, stall_cnt_d;

  // Combinational handshake / grant signals
  logic a_held, b_held;
  logic grant_a, grant_b;
  logic a_accept, b_accept;
  logic stall_now;

  // Saturating increment for the stall counter; sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  // Round-robin grant and ready: a held entry alone always wins; on a tie the
  // requester that did not win last time goes first. Ready ignores valid so a
  // sole requester can stream one write per cycle (grant frees the slot).
  always_comb begin
    a_held   = (a_state_q == HELD);
    b_held   = (b_state_q == HELD);
    grant_a  = a_held && (!b_held || (last_grant_q == GNT_B));
    grant_b  = b_held && (!a_held || (last_grant_q == GNT_A));
    a_ready  = rst_n && (!a_held || grant_a);
    b_ready  = rst_n && (!b_held || grant_b);
    a_accept = a_valid && a_ready;
    b_accept = b_valid && b_ready;
    stall_now = (a_held && !grant_a) || (b_held && !grant_b);
  end

  // Holding buffer next state: a new accept (re)loads the entry, even in the
  // cycle the previous contents are granted; a bare grant empties it.
  always_comb begin
    a_state_d = a_state_q;
    a_waddr_d = a_waddr_q;
    a_dataA_d = a_dataA_q;
    a_dataB_d = a_dataB_q;
    if (a_accept) begin
      a_state_d = HELD;
      a_waddr_d = a_waddr;
      a_dataA_d = a_dataA;
      a_dataB_d = a_dataB;
    end else if (grant_a) begin
      a_state_d = EMPTY;
    end

    b_state_d = b_state_q;
    b_waddr_d = b_waddr_q;
    b_dataA_d = b_dataA_q;
    b_dataB_d = b_dataB_q;
    if (b_accept) begin
      b_state_d = HELD;
      b_waddr_d = b_waddr;
      b_dataA_d = b_dataA;
      b_dataB_d = b_dataB;
    end else if (grant_b) begin
      b_state_d = EMPTY;
    end
  end

  // Output next state: load the winner; address 0 is consumed silently.
  // With no grant, the write enable drops and address/data keep their values.
  always_comb begin
    rf_write_en_d = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_data_inA_d = rf_data_inA_q;
    rf_data_inB_d = rf_data_inB_q;
    last_grant_d  = last_grant_q;
    stall_cnt_d   = stall_cnt_q;
    if (grant_a) begin
      rf_write_en_d = (a_waddr_q != '0);
      rf_waddr_d    = a_waddr_q;
      rf_data_inA_d = a_dataA_q;
      rf_data_inB_d = a_dataB_q;
      last_grant_d  = GNT_A;
    end else if (grant_b) begin
      rf_write_en_d = (b_waddr_q != '0);
      rf_waddr_d    = b_waddr_q;
      rf_data_inA_d = b_dataA_q;
      rf_data_inB_d = b_dataB_q;
      last_grant_d  = GNT_B;
    end
    if (stall_now) begin
      stall_cnt_d = sat_inc8(stall_cnt_q);
    end
  end

  // Control state: buffer FSMs, round-robin pointer and register-file outputs.
  // Reset discards held entries and leaves B as last winner so A wins first tie.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      a_state_q     <= EMPTY;
      b_state_q     <= EMPTY;
      last_grant_q  <= GNT_B;
      rf_write_en_q <= 1'b0;
      rf_waddr_q    <= '0;
      rf_data_inA_q <= '0;
      rf_data_inB_q <= '0;
      stall_cnt_q   <= 8'd0;
    end else begin
      a_state_q     <= a_state_d;
      b_state_q     <= b_state_d;
      last_grant_q  <= last_grant_d;
      rf_write_en_q <= rf_write_en_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_data_inA_q <= rf_data_inA_d;
      rf_data_inB_q <= rf_data_inB_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Buffer payload: only meaningful while HELD, so it needs no reset.
  always_ff @(posedge CLK) begin
    a_waddr_q <= a_waddr_d;
    a_dataA_q <= a_dataA_d;
    a_dataB_q <= a_dataB_d;
    b_waddr_q <= b_waddr_d;
    b_dataA_q <= b_dataA_d;
    b_dataB_q <= b_dataB_d;
  end

  assign rf_write_en = rf_write_en_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_data_inA = rf_data_inA_q;
  assign rf_data_inB = rf_data_inB_q;
  assign stall_cnt   = stall_cnt_q;

`ifdef RF_BYPASS_EN
  logic [D-1:0] rf_waddr_p1;

  // Forward the write in flight this cycle to each read port; the pair's
  // second word lands at waddr+1, which wraps modulo the register count.
  always_comb begin
    rf_waddr_p1 = rf_waddr_q + D'(1);
    byp_doutA   = rf_doutA;
    byp_doutB   = rf_doutB;
    if (rf_write_en_q && (rd_addrA == rf_waddr_q)) begin
      byp_doutA = rf_data_inA_q;
    end else if (rf_write_en_q && (rd_addrA == rf_waddr_p1)) begin
      byp_doutA = rf_data_inB_q;
    end
    if (rf_write_en_q && (rd_addrB == rf_waddr_q)) begin
      byp_doutB = rf_data_inA_q;
    end else if (rf_write_en_q && (rd_addrB == rf_waddr_p1)) begin
      byp_doutB = rf_data_inB_q;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for rf_write_arbiter.
// Expected register-file writes are queued in predicted grant order when the
// stimulus is driven; a negedge monitor pops one entry per observed write.
module tb_rf_write_arbiter;
  localparam int W = 8;
  localparam int D = 3;

  logic         CLK;
  logic         rst_n;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [D-1:0] a_waddr, b_waddr;
  logic [W-1:0] a_dataA, a_dataB, b_dataA, b_dataB;
  logic         rf_write_en;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_data_inA, rf_data_inB;
  logic [7:0]   stall_cnt;
`ifdef RF_BYPASS_EN
  logic [D-1:0] rd_addrA, rd_addrB;
  logic [W-1:0] rf_doutA, rf_doutB, byp_doutA, byp_doutB;
`endif

  int total = 0;
  int bad   = 0;

  // Expected write: {waddr, dataA, dataB}
  logic [D+2*W-1:0] exp_q[$];

  rf_write_arbiter #(.W(W), .D(D)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr),
    .a_dataA(a_dataA), .a_dataB(a_dataB),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr),
    .b_dataA(b_dataA), .b_dataB(b_dataB),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr),
    .rf_data_inA(rf_data_inA), .rf_data_inB(rf_data_inB),
    .stall_cnt(stall_cnt)
`ifdef RF_BYPASS_EN
    ,
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rf_doutA(rf_doutA), .rf_doutB(rf_doutB),
    .byp_doutA(byp_doutA), .byp_doutB(byp_doutB)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every observed write must match the queue head.
  always @(negedge CLK) begin
    if (rst_n && rf_write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, rf_waddr, rf_data_inA, rf_data_inB}, 32'hFFFF_FFFF);
      end else begin
        check("sb_write", {13'd0, rf_waddr, rf_data_inA, rf_data_inB},
              {13'd0, exp_q.pop_front()});
      end
    end
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [D-1:0] beat_addr(input bit is_b, input int i);
    return is_b ? D'(((i + 3) % 7) + 1) : D'((i % 7) + 1);
  endfunction
  function automatic logic [W-1:0] beat_da(input bit is_b, input int i);
    return is_b ? W'(8'hC0 + i) : W'(8'h40 + i);
  endfunction
  function automatic logic [W-1:0] beat_db(input bit is_b, input int i);
    return is_b ? W'(8'hD0 + i) : W'(8'h60 + i);
  endfunction

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_waddr = '0; a_dataA = '0; a_dataB = '0;
    b_waddr = '0; b_dataA = '0; b_dataB = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    check("drain", exp_q.size(), 0);
  endtask

  // Both requesters valid for n cycles. Grants alternate A,B,... from A,
  // so the first n+1 accepted beats are written in that interleaved order.
  task automatic run_both(input int n);
    int ia = 0;
    int ib = 0;
    for (int k = 0; k <= n; k++) begin
      exp_q.push_back({beat_addr(k[0], k / 2), beat_da(k[0], k / 2), beat_db(k[0], k / 2)});
    end
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      a_valid = 1'b1; a_waddr = beat_addr(1'b0, ia);
      a_dataA = beat_da(1'b0, ia); a_dataB = beat_db(1'b0, ia);
      b_valid = 1'b1; b_waddr = beat_addr(1'b1, ib);
      b_dataA = beat_da(1'b1, ib); b_dataB = beat_db(1'b1, ib);
      #1;
      check("rr_a_ready", a_ready, (k == 0 || k % 2 == 1) ? 1 : 0);
      check("rr_b_ready", b_ready, (k == 0 || k % 2 == 0) ? 1 : 0);
      if (a_ready) ia++;
      if (b_ready) ib++;
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
`ifdef RF_BYPASS_EN
    rd_addrA = '0; rd_addrB = '0; rf_doutA = 8'h5A; rf_doutB = 8'hA5;
`endif
    do_reset();
    #1;
    check("rst_we", rf_write_en, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_dA", rf_data_inA, 0);
    check("rst_dB", rf_data_inB, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);

    // 1: single A write, one cycle of write_en
    @(negedge CLK);
    a_valid = 1'b1; a_waddr = 3'd2; a_dataA = 8'h11; a_dataB = 8'h22;
    exp_q.push_back({3'd2, 8'h11, 8'h22});
    @(negedge CLK);
    idle_inputs();
    check("t1_we_early", rf_write_en, 0);
    @(negedge CLK);
    check("t1_we", rf_write_en, 1);
    check("t1_waddr", rf_waddr, 2);
    @(negedge CLK);
    check("t1_we_drop", rf_write_en, 0);
    check("t1_hold_addr", rf_waddr, 2);
    check("t1_stall", stall_cnt, 0);

    // 2: simultaneous accept after reset -> A then B, one stall cycle
    do_reset();
    @(negedge CLK);
    a_valid = 1'b1; a_waddr = 3'd1; a_dataA = 8'h31; a_dataB = 8'h32;
    b_valid = 1'b1; b_waddr = 3'd4; b_dataA = 8'h41; b_dataB = 8'h42;
    exp_q.push_back({3'd1, 8'h31, 8'h32});
    exp_q.push_back({3'd4, 8'h41, 8'h42});
    @(negedge CLK);
    idle_inputs();
    #1;
    check("t2_a_ready", a_ready, 1);
    check("t2_b_ready", b_ready, 0);
    @(negedge CLK);
    check("t2_first", rf_waddr, 1);
    check("t2_stall1", stall_cnt, 1);
    @(negedge CLK);
    check("t2_second", rf_waddr, 4);
    check("t2_stall", stall_cnt, 1);
    wait_drain();

    // 3: both continuously valid for 6 cycles -> alternating grants
    do_reset();
    run_both(6);
    wait_drain();
    check("t3_stall", stall_cnt, 6);

    // 4: B address 0 is consumed silently and takes B's round-robin turn
    do_reset();
    @(negedge CLK);
    a_valid = 1'b1; a_waddr = 3'd3; a_dataA = 8'h13; a_dataB = 8'h14;
    exp_q.push_back({3'd3, 8'h13, 8'h14});
    @(negedge CLK);
    idle_inputs();
    b_valid = 1'b1; b_waddr = 3'd0; b_dataA = 8'hEE; b_dataB = 8'hEF;
    #1;
    check("t4_b_ready", b_ready, 1);
    @(negedge CLK);
    idle_inputs();
    check("t4_a_out", rf_waddr, 3);
    @(negedge CLK);
    check("t4_zero_dropped", rf_write_en, 0);
    a_valid = 1'b1; a_waddr = 3'd5; a_dataA = 8'h51; a_dataB = 8'h52;
    b_valid = 1'b1; b_waddr = 3'd6; b_dataA = 8'h61; b_dataB = 8'h62;
    exp_q.push_back({3'd5, 8'h51, 8'h52});
    exp_q.push_back({3'd6, 8'h61, 8'h62});
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    check("t4_tie_to_a", rf_waddr, 5);
    wait_drain();

    // 5: reset right after an accept discards the held entry
    do_reset();
    @(negedge CLK);
    a_valid = 1'b1; a_waddr = 3'd2; a_dataA = 8'h55; a_dataB = 8'h66;
    @(negedge CLK);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("t5_ready_in_rst", a_ready, 0);
    @(negedge CLK);
    check("t5_we", rf_write_en, 0);
    check("t5_waddr", rf_waddr, 0);
    check("t5_dA", rf_data_inA, 0);
    check("t5_dB", rf_data_inB, 0);
    rst_n = 1'b1;
    #1;
    check("t5_a_ready", a_ready, 1);
    @(negedge CLK);
    check("t5_no_write", rf_write_en, 0);

    // Top address is issued unchanged
    @(negedge CLK);
    a_valid = 1'b1; a_waddr = 3'd7; a_dataA = 8'hAA; a_dataB = 8'hBB;
    exp_q.push_back({3'd7, 8'hAA, 8'hBB});
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    check("top_addr", rf_waddr, 7);
`ifdef RF_BYPASS_EN
    // 6: forwarding of both words, second one wrapping to register 0
    rd_addrA = 3'd7; rd_addrB = 3'd0;
    #1;
    check("t6_bypA", byp_doutA, 8'hAA);
    check("t6_bypB", byp_doutB, 8'hBB);
    rd_addrA = 3'd3;
    #1;
    check("t6_noByp", byp_doutA, 8'h5A);
    @(negedge CLK);
    rd_addrA = 3'd7;
    #1;
    check("t6_idle", byp_doutA, 8'h5A);
`endif
    wait_drain();

    // Stall counter saturation under a long contention run
    do_reset();
    run_both(300);
    wait_drain();
    check("stall_sat", stall_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
